// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for the pipelined floating-point multiplier.
// The master drives operands and out_ready; the slave (the multiplier) drives the rest.
interface fp_mul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage flush-to-zero floating-point multiplier with round-to-nearest-even
// and a valid/ready elastic pipeline (unpack/classify, multiply, normalise/round/pack).
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_mul_pipe_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic [EW-1:0]        BIAS     = EW'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'(2 ** EXP_W - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic r_v1, r_v2, r_v3;
    logic w_adv1, w_adv2, w_adv3;

    logic [W-1:0] r_result;
    logic [3:0]   r_flags;

    // A stage moves when it is empty or its successor moves, so bubbles collapse.
    assign w_adv3 = !r_v3 || bus.out_ready;
    assign w_adv2 = !r_v2 || w_adv3;
    assign w_adv1 = !r_v1 || w_adv2;

    assign bus.in_ready  = w_adv1;
    assign bus.out_valid = r_v3;
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;

    logic [EXP_W-1:0] w_aExp, w_bExp;
    logic [MAN_W-1:0] w_aMan, w_bMan;
    logic             w_sign;
    logic             w_aZero, w_bZero, w_aInf, w_bInf, w_aNaN, w_bNaN;
    logic             w_spec;
    logic [W-1:0]     w_specRes;
    logic [3:0]       w_specFlags;

    assign w_aExp  = bus.a[W-2:MAN_W];
    assign w_bExp  = bus.b[W-2:MAN_W];
    assign w_aMan  = bus.a[MAN_W-1:0];
    assign w_bMan  = bus.b[MAN_W-1:0];
    assign w_sign  = bus.a[W-1] ^ bus.b[W-1];
    assign w_aZero = (w_aExp == '0);
    assign w_bZero = (w_bExp == '0);
    assign w_aInf  = (w_aExp == '1) && (w_aMan == '0);
    assign w_bInf  = (w_bExp == '1) && (w_bMan == '0);
    assign w_aNaN  = (w_aExp == '1) && (w_aMan != '0);
    assign w_bNaN  = (w_bExp == '1) && (w_bMan != '0);

    // Subnormals count as zero here, so inf x subnormal is also invalid.
    always_comb begin
        w_spec      = 1'b1;
        w_specRes   = {w_sign, {(W-1){1'b0}}};
        w_specFlags = 4'b0000;
        if (w_aNaN || w_bNaN || (w_aInf && w_bZero) || (w_bInf && w_aZero)) begin
            w_specRes   = QNAN;
            w_specFlags = {(w_aNaN && !w_aMan[MAN_W-1]) || (w_bNaN && !w_bMan[MAN_W-1]) ||
                           (w_aInf && w_bZero) || (w_bInf && w_aZero), 3'b000};
        end else if (w_aInf || w_bInf) begin
            w_specRes = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (!(w_aZero || w_bZero)) begin
            w_spec = 1'b0;
        end
    end

    logic             r_s1Sign, r_s1Spec;
    logic [EXP_W-1:0] r_s1AExp, r_s1BExp;
    logic [MAN_W:0]   r_s1AMan, r_s1BMan;
    logic [W-1:0]     r_s1SpecRes;
    logic [3:0]       r_s1SpecFlags;

    logic                 r_s2Sign, r_s2Spec;
    logic signed [EW-1:0] r_s2Exp;
    logic [PW-1:0]        r_s2Prod;
    logic [W-1:0]         r_s2SpecRes;
    logic [3:0]           r_s2SpecFlags;

    always_ff @(posedge clk) begin
        if (w_adv1 && bus.in_valid) begin
            r_s1Sign      <= w_sign;
            r_s1AExp      <= w_aExp;
            r_s1BExp      <= w_bExp;
            r_s1AMan      <= {1'b1, w_aMan};
            r_s1BMan      <= {1'b1, w_bMan};
            r_s1Spec      <= w_spec;
            r_s1SpecRes   <= w_specRes;
            r_s1SpecFlags <= w_specFlags;
        end
        if (w_adv2 && r_v1) begin
            r_s2Sign      <= r_s1Sign;
            r_s2Exp       <= EW'(r_s1AExp) + EW'(r_s1BExp) - BIAS;
            r_s2Prod      <= r_s1AMan * r_s1BMan;
            r_s2Spec      <= r_s1Spec;
            r_s2SpecRes   <= r_s1SpecRes;
            r_s2SpecFlags <= r_s1SpecFlags;
        end
    end

    logic                 w_msb, w_guard, w_round, w_sticky, w_roundUp, w_inexact;
    logic [PW-1:0]        w_norm;
    logic [MAN_W+1:0]     w_manRnd;
    logic [MAN_W-1:0]     w_frac;
    logic signed [EW-1:0] w_expFin;
    logic [W-1:0]         w_res3;
    logic [3:0]           w_flags3;

    // After normalising, the leading one sits in the top bit of w_norm.
    assign w_msb     = r_s2Prod[PW-1];
    assign w_norm    = w_msb ? r_s2Prod : {r_s2Prod[PW-2:0], 1'b0};
    assign w_guard   = w_norm[MAN_W];
    assign w_round   = w_norm[MAN_W-1];
    assign w_sticky  = |w_norm[MAN_W-2:0];
    assign w_roundUp = w_guard && (w_round || w_sticky || w_norm[MAN_W+1]);
    assign w_inexact = w_guard || w_round || w_sticky;
    assign w_manRnd  = {1'b0, w_norm[PW-1:MAN_W+1]} + {{(MAN_W+1){1'b0}}, w_roundUp};
    assign w_frac    = w_manRnd[MAN_W+1] ? w_manRnd[MAN_W:1] : w_manRnd[MAN_W-1:0];
    assign w_expFin  = r_s2Exp + EW'(w_msb) + EW'(w_manRnd[MAN_W+1]);

    always_comb begin
        w_res3   = {r_s2Sign, w_expFin[EXP_W-1:0], w_frac};
        w_flags3 = {3'b000, w_inexact};
        if (r_s2Spec) begin
            w_res3   = r_s2SpecRes;
            w_flags3 = r_s2SpecFlags;
        end else if (w_expFin >= EXP_MAX) begin
            w_res3   = {r_s2Sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags3 = 4'b0101;
        end else if (w_expFin <= EXP_ZERO) begin
            w_res3   = {r_s2Sign, {(W-1){1'b0}}};
            w_flags3 = 4'b0011;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            if (w_adv1) r_v1 <= bus.in_valid;
            if (w_adv2) r_v2 <= r_v1;
            if (w_adv3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_result <= w_res3;
                    r_flags  <= w_flags3;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed vector table, stall/reset sequences, and a random
// stream scored against an arithmetic single-precision reference model.
module tb_fp_mul_pipe;
    logic clk;
    logic rst_n;

    fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    vec_t        vecs[15];
    logic [35:0] expQ[$];
    int          testCount = 0;
    int          failCount = 0;
    int          outCount  = 0;
    logic        gAccepted = 1'b0;
    logic        gInReady  = 1'b0;
    logic        holdPending = 1'b0;
    logic [31:0] heldRes   = '0;
    logic [3:0]  heldFlags = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Exact integer product, then round-to-nearest-even by remainder against half an ulp.
    function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic [3:0] f);
        int ea, eb, e, top, sh;
        logic sign, aNan, bNan, aInf, bInf, aZero, bZero, inexact;
        longint unsigned p, kept, rem, half;
        ea    = int'(a[30:23]);
        eb    = int'(b[30:23]);
        sign  = a[31] ^ b[31];
        aNan  = (ea == 255) && (a[22:0] != 0);
        bNan  = (eb == 255) && (b[22:0] != 0);
        aInf  = (ea == 255) && (a[22:0] == 0);
        bInf  = (eb == 255) && (b[22:0] == 0);
        aZero = (ea == 0);
        bZero = (eb == 0);
        r = '0;
        f = '0;
        if (aNan || bNan || (aInf && bZero) || (bInf && aZero)) begin
            r    = 32'h7FC00000;
            f[3] = (aNan && !a[22]) || (bNan && !b[22]) || (aInf && bZero) || (bInf && aZero);
        end else if (aInf || bInf) begin
            r = {sign, 8'hFF, 23'h0};
        end else if (aZero || bZero) begin
            r = {sign, 31'h0};
        end else begin
            p   = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
            top = 63;
            while (top > 0 && p[top] == 1'b0) top--;
            sh      = top - 23;
            kept    = p >> sh;
            rem     = p - (kept << sh);
            half    = 64'd1 << (sh - 1);
            e       = ea + eb - 127 + (top - 46);
            inexact = (rem != 0);
            if (rem > half || (rem == half && kept[0])) kept = kept + 1;
            if (kept == (64'd1 << 24)) begin
                kept = kept >> 1;
                e    = e + 1;
            end
            if (e >= 255) begin
                r = {sign, 8'hFF, 23'h0};
                f = 4'b0101;
            end else if (e <= 0) begin
                r = {sign, 31'h0};
                f = 4'b0011;
            end else begin
                r = {sign, e[7:0], kept[22:0]};
                f = {3'b000, inexact};
            end
        end
    endfunction

    function automatic logic [31:0] randOperand();
        int         k;
        logic       s;
        logic [7:0] e;
        logic [22:0] m;
        k = $urandom_range(0, 19);
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        if (k == 0)      e = 8'd0;
        else if (k == 1) begin e = 8'hFF; m = '0; end
        else if (k == 2) begin e = 8'hFF; m = m | 23'h1; end
        else if (k == 3) begin e = 8'd0;  m = m | 23'h1; end
        else if (k < 8)  e = 8'($urandom_range(1, 254));
        else             e = 8'($urandom_range(100, 154));
        if (k == 8) m = m & 23'h7F0000;
        return {s, e, m};
    endfunction

    // One operation on an empty pipe with out_ready high; checks latency and value.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] res, input logic [3:0] flg, input string name);
        int n, lat;
        bus.a         = a;
        bus.b         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({name, "_lat"}, 32'(lat), 32'd3);
        checkOutput({name, "_res"}, bus.result, res);
        checkOutput({name, "_flg"}, {28'b0, bus.flags}, {28'b0, flg});
        @(posedge clk); #1;
    endtask

    // Samples both handshakes mid-cycle, scores outputs in order and checks stall holds.
    task automatic stepCycle();
        logic [31:0] r;
        logic [3:0]  f;
        logic [35:0] e;
        @(negedge clk);
        gInReady  = bus.in_ready;
        gAccepted = bus.in_valid && bus.in_ready;
        if (gAccepted) begin
            refModel(bus.a, bus.b, r, f);
            expQ.push_back({f, r});
        end
        if (holdPending) begin
            checkOutput("stallValid",  {31'b0, bus.out_valid}, 32'd1);
            checkOutput("stallResult", bus.result, heldRes);
            checkOutput("stallFlags",  {28'b0, bus.flags}, {28'b0, heldFlags});
        end
        holdPending = bus.out_valid && !bus.out_ready;
        heldRes     = bus.result;
        heldFlags   = bus.flags;
        if (bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
                testCount++;
                failCount++;
                $display("[TB] FAIL unexpectedOut: got result 0x%08h, expected no output", bus.result);
            end else begin
                e = expQ.pop_front();
                checkOutput("streamResult", bus.result, e[31:0]);
                checkOutput("streamFlags", {28'b0, bus.flags}, {28'b0, e[35:32]});
                outCount++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (expQ.size() != 0 && n < 30) begin
            stepCycle();
            n++;
        end
        checkOutput("drainEmpty", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        logic pending;
        int   nAcc, outStart;
        logic sawLow;

        vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
        vecs[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};
        vecs[2]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101};
        vecs[3]  = '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011};
        vecs[4]  = '{32'h7F800000, 32'h80000000, 32'h7FC00000, 4'b1000};
        vecs[5]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
        vecs[6]  = '{32'h3FC00000, 32'h3F800001, 32'h3FC00002, 4'b0001};
        vecs[7]  = '{32'h3FC00000, 32'h3F800003, 32'h3FC00004, 4'b0001};
        vecs[8]  = '{32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 4'b0001};
        vecs[9]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000};
        vecs[10] = '{32'hFF800001, 32'h3F800000, 32'h7FC00000, 4'b1000};
        vecs[11] = '{32'h80000000, 32'hC0000000, 32'h00000000, 4'b0000};
        vecs[12] = '{32'h80000001, 32'h40000000, 32'h80000000, 4'b0000};
        vecs[13] = '{32'h00000001, 32'hFF800000, 32'h7FC00000, 4'b1000};
        vecs[14] = '{32'hC0400000, 32'h40800000, 32'hC1400000, 4'b0000};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("rstOutValid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("rstResult", bus.result, 32'd0);
        checkOutput("rstFlags", {28'b0, bus.flags}, 32'd0);
        checkOutput("rstInReady", {31'b0, bus.in_ready}, 32'd1);

        foreach (vecs[i])
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg, $sformatf("vec%0d", i));

        // Five back-to-back operations with the sink stalled in cycles 4..7.
        nAcc     = 0;
        outStart = outCount;
        sawLow   = 1'b0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            bus.in_valid  = (nAcc < 5);
            bus.a         = 32'h40400000 + 32'(nAcc * 4097);
            bus.b         = 32'h3FC00000 + 32'(nAcc);
            bus.out_ready = !(cyc >= 4 && cyc <= 7);
            stepCycle();
            if (gAccepted) nAcc++;
            if (!gInReady) sawLow = 1'b1;
        end
        checkOutput("burstAccepted", 32'(nAcc), 32'd5);
        checkOutput("burstOutputs", 32'(outCount - outStart), 32'd5);
        checkOutput("burstInReadyDrop", {31'b0, sawLow}, 32'd1);
        drain();

        // Reset with two operations in flight must discard both.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 32'h40000000 + 32'(i);
            bus.b        = 32'h40400000;
            stepCycle();
        end
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        expQ.delete();
        holdPending = 1'b0;
        checkOutput("midRstInReady", {31'b0, bus.in_ready}, 32'd1);
        checkOutput("midRstResult", bus.result, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("midRstNoStale", {31'b0, bus.out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        applyStimulus(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, "postRst");

        // Random stream with random source gaps and sink back-pressure.
        pending = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (!pending && $urandom_range(0, 3) != 0) begin
                bus.a   = randOperand();
                bus.b   = randOperand();
                pending = 1'b1;
            end
            bus.in_valid  = pending;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            stepCycle();
            if (gAccepted) pending = 1'b0;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8: exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 23: stored mantissa width; word width W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands a/b are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-007 The block SHALL have ports a and b, input, W bits each: IEEE-754-style operands {sign, exp, man}.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result/flags valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-010 The block SHALL have port result, output, W bits: the product.
REQ-011 The block SHALL have port flags, output, 4 bits: {invalid, overflow, underflow, inexact}, qualified by out_valid.

Function
REQ-012 Transfers SHALL occur only on cycles with valid && ready on the same side.
REQ-013 The pipeline SHALL have exactly 3 stages (S1 unpack/classify, S2 mantissa multiply/exponent add, S3 normalise/round/pack), each with its own valid bit.
REQ-014 Latency SHALL be 3 cycles from input handshake to out_valid when out_ready stays high; throughput SHALL be one operation per cycle.
REQ-015 Stall: a stage SHALL advance when it is empty or the next stage advances; in_ready = !S1 valid || S1 advances; out_valid = S3 valid; bubbles SHALL collapse.
REQ-016 While out_valid=1 and out_ready=0, result and flags SHALL hold stable and no operation SHALL be lost or duplicated.
REQ-017 Sign SHALL equal a[W-1] XOR b[W-1] for every result, including zero and infinity; NaN results SHALL be positive.
REQ-018 Subnormal inputs (exp=0, man!=0) SHALL be treated as signed zero (flush-to-zero); no flag SHALL be raised for this.
REQ-019 Mantissa product SHALL be the full (MAN_W+1)x(MAN_W+1) = 2*MAN_W+2-bit product of operands with the hidden 1 restored.
REQ-020 The unbiased exponent SHALL be computed as signed EXP_W+2 bits: ea+eb-BIAS, +1 if the product MSB is set (with a right shift by one).
REQ-021 Rounding SHALL be round-to-nearest-even using guard, round and sticky (OR of all lower bits); a mantissa carry-out from rounding SHALL increment the exponent.
REQ-022 inexact SHALL be set when any discarded bit is non-zero, or on overflow/underflow to zero from a non-zero exact product.
REQ-023 If the final exponent is >= 2^EXP_W-1, the result SHALL be signed infinity with overflow=1 and inexact=1.
REQ-024 If the final exponent is <= 0, the result SHALL be signed zero with underflow=1 and inexact=1 (flush-to-zero output).
REQ-025 Any NaN operand, or infinity x zero, SHALL give canonical qNaN {0, all-ones exp, 1, zeros}; invalid=1 for inf x zero or a signalling NaN (man MSB=0), otherwise flags=0.
REQ-026 Infinity x finite non-zero SHALL give signed infinity with flags=0; zero x finite SHALL give signed zero with flags=0.
REQ-027 Special-case classification SHALL take priority over the arithmetic path in S3.

Reset
REQ-028 On rising clk with rst_n=0, all stage valid bits SHALL clear; out_valid=0, result=0 and flags=0; in_ready SHALL read 1 on the first cycle after reset.
REQ-029 Reset mid-operation SHALL discard all in-flight operations; no out_valid SHALL follow for them.
REQ-030 Data registers other than result/flags SHALL need no reset.

Verification
REQ-031 0x3FC00000 x 0x40000000 with out_ready=1 -> 3 cycles later result=0x40400000, flags=0.
REQ-032 0x3F800001 x 0x3F800001 -> result=0x3F800002, flags=0001 (inexact, RNE).
REQ-033 0x7F7FFFFF x 0x40000000 -> 0x7F800000, flags=0101; 0x00800000 x 0x00800000 -> 0x00000000, flags=0011.
REQ-034 0x7F800000 x 0x80000000 -> 0x7FC00000, flags=1000; 0xFF800000 x 0x40000000 -> 0xFF800000, flags=0000.
REQ-035 Stream of 5 back-to-back operations with out_ready held low for cycles 4-7 -> in_ready drops once the pipe fills, all 5 results emerge in order, and outputs are stable while stalled.
REQ-036 rst_n=0 for one cycle with 2 operations in flight -> out_valid=0 afterwards, no stale result is emitted, and the next operation completes in 3 cycles.
